// File: rtl/yasac_control_unit.sv
// YASAC multi-cycle control unit: sequences fetch and execute for the data unit
// and decodes every data-unit control strobe from state, OPCODE and STATUS.
module yasac_control_unit #(
    parameter logic [3:0] ALU_PASS_A = 4'hE,
    parameter logic [3:0] ALU_PASS_B = 4'hF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [4:0] OPCODE,
    input  logic [2:0] STATUS_SEL,
    input  logic [7:0] STATUS,
    output logic [3:0] ALU_OPERATION,
    output logic       INC_PROGCOUNT,
    output logic       CLR_PROGCOUNT,
    output logic       WRITE_PROGCOUNT,
    output logic       READ_PROGCOUNT,
    output logic       WRITE_INSTREG,
    output logic       WRITE_REGS,
    output logic       USE_IMMEDIATE,
    output logic       USE_DISPLACEMENT,
    output logic       WRITE_MEM,
    output logic       READ_MEM,
    output logic       WRITE_MEMADDR,
    output logic       WRITE_STATREG,
    output logic       CLR_STATBIT,
    output logic       SET_STATBIT,
    output logic       PRESET_STACKPTR,
    output logic       INC_STACKPTR,
    output logic       DEC_STACKPTR,
    output logic       READ_STACKPTR,
    output logic       HALTED
);

    localparam logic [4:0] OP_LDI  = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_ST   = 5'b10010;
    localparam logic [4:0] OP_JMP  = 5'b10011;
    localparam logic [4:0] OP_BRS  = 5'b10100;
    localparam logic [4:0] OP_BRC  = 5'b10101;
    localparam logic [4:0] OP_CLS  = 5'b10110;
    localparam logic [4:0] OP_SES  = 5'b10111;
    localparam logic [4:0] OP_PUSH = 5'b11000;
    localparam logic [4:0] OP_POP  = 5'b11001;
    localparam logic [4:0] OP_CALL = 5'b11010;
    localparam logic [4:0] OP_RET  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StE1,
        StE2,
        StE3,
        StHalt
    } state_e;

    state_e state_q, state_d;
    logic   branch_taken;

    // BRS takes the branch on a set bit, BRC on a clear bit.
    assign branch_taken = STATUS[STATUS_SEL] == (OPCODE == OP_BRS);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StInit:  state_d = StFetch;
            StFetch: state_d = StE1;
            StE1: begin
                if (OPCODE == OP_HALT) begin
                    state_d = StHalt;
                end else if (OPCODE inside {OP_LD, OP_ST, OP_PUSH, OP_POP, OP_CALL, OP_RET}) begin
                    state_d = StE2;
                end
            end
            StE2: begin
                if (OPCODE inside {OP_POP, OP_CALL, OP_RET}) begin
                    state_d = StE3;
                end
            end
            StE3:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        ALU_OPERATION    = 4'h0;
        INC_PROGCOUNT    = 1'b0;
        CLR_PROGCOUNT    = 1'b0;
        WRITE_PROGCOUNT  = 1'b0;
        READ_PROGCOUNT   = 1'b0;
        WRITE_INSTREG    = 1'b0;
        WRITE_REGS       = 1'b0;
        USE_IMMEDIATE    = 1'b0;
        USE_DISPLACEMENT = 1'b0;
        WRITE_MEM        = 1'b0;
        READ_MEM         = 1'b0;
        WRITE_MEMADDR    = 1'b0;
        WRITE_STATREG    = 1'b0;
        CLR_STATBIT      = 1'b0;
        SET_STATBIT      = 1'b0;
        PRESET_STACKPTR  = 1'b0;
        INC_STACKPTR     = 1'b0;
        DEC_STACKPTR     = 1'b0;
        READ_STACKPTR    = 1'b0;
        HALTED           = 1'b0;
        unique case (state_q)
            StInit: begin
                CLR_PROGCOUNT   = 1'b1;
                PRESET_STACKPTR = 1'b1;
            end
            StFetch: begin
                WRITE_INSTREG = 1'b1;
                INC_PROGCOUNT = 1'b1;
            end
            StE1: begin
                if (!OPCODE[4]) begin
                    ALU_OPERATION = OPCODE[3:0];
                    WRITE_REGS    = 1'b1;
                    WRITE_STATREG = 1'b1;
                end else begin
                    case (OPCODE)
                        OP_LDI: begin
                            USE_IMMEDIATE = 1'b1;
                            ALU_OPERATION = ALU_PASS_B;
                            WRITE_REGS    = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            USE_IMMEDIATE = 1'b1;
                            ALU_OPERATION = ALU_PASS_B;
                            WRITE_MEMADDR = 1'b1;
                        end
                        OP_JMP: begin
                            USE_IMMEDIATE   = 1'b1;
                            ALU_OPERATION   = ALU_PASS_B;
                            WRITE_PROGCOUNT = 1'b1;
                        end
                        OP_BRS, OP_BRC: begin
                            if (branch_taken) begin
                                USE_IMMEDIATE   = 1'b1;
                                ALU_OPERATION   = ALU_PASS_B;
                                WRITE_PROGCOUNT = 1'b1;
                            end
                        end
                        OP_CLS: CLR_STATBIT = 1'b1;
                        OP_SES: SET_STATBIT = 1'b1;
                        OP_PUSH, OP_CALL: begin
                            READ_STACKPTR = 1'b1;
                            WRITE_MEMADDR = 1'b1;
                            DEC_STACKPTR  = 1'b1;
                        end
                        OP_POP, OP_RET: INC_STACKPTR = 1'b1;
                        default: ;
                    endcase
                end
            end
            StE2: begin
                case (OPCODE)
                    OP_LD: begin
                        READ_MEM   = 1'b1;
                        WRITE_REGS = 1'b1;
                    end
                    OP_ST, OP_PUSH: begin
                        ALU_OPERATION = ALU_PASS_A;
                        WRITE_MEM     = 1'b1;
                    end
                    OP_POP, OP_RET: begin
                        READ_STACKPTR = 1'b1;
                        WRITE_MEMADDR = 1'b1;
                    end
                    OP_CALL: begin
                        READ_PROGCOUNT = 1'b1;
                        WRITE_MEM      = 1'b1;
                    end
                    default: ;
                endcase
            end
            StE3: begin
                case (OPCODE)
                    OP_POP: begin
                        READ_MEM   = 1'b1;
                        WRITE_REGS = 1'b1;
                    end
                    OP_CALL: begin
                        USE_IMMEDIATE   = 1'b1;
                        ALU_OPERATION   = ALU_PASS_B;
                        WRITE_PROGCOUNT = 1'b1;
                    end
                    OP_RET: begin
                        READ_MEM        = 1'b1;
                        WRITE_PROGCOUNT = 1'b1;
                    end
                    default: ;
                endcase
            end
            StHalt:  HALTED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_yasac_control_unit.sv
// Self-checking bench for yasac_control_unit: per-instruction expected strobe
// sequences are queued from the instruction table and compared cycle by cycle.
module tb_yasac_control_unit;

    localparam logic [3:0] PA = 4'hE;
    localparam logic [3:0] PB = 4'hF;

    localparam logic [18:0] M_INC_PC  = 19'd1 << 0;
    localparam logic [18:0] M_CLR_PC  = 19'd1 << 1;
    localparam logic [18:0] M_WPC     = 19'd1 << 2;
    localparam logic [18:0] M_RPC     = 19'd1 << 3;
    localparam logic [18:0] M_WIR     = 19'd1 << 4;
    localparam logic [18:0] M_WREGS   = 19'd1 << 5;
    localparam logic [18:0] M_IMM     = 19'd1 << 6;
    localparam logic [18:0] M_DISP    = 19'd1 << 7;
    localparam logic [18:0] M_WMEM    = 19'd1 << 8;
    localparam logic [18:0] M_RMEM    = 19'd1 << 9;
    localparam logic [18:0] M_WMA     = 19'd1 << 10;
    localparam logic [18:0] M_WSTAT   = 19'd1 << 11;
    localparam logic [18:0] M_CLRB    = 19'd1 << 12;
    localparam logic [18:0] M_SETB    = 19'd1 << 13;
    localparam logic [18:0] M_PSP     = 19'd1 << 14;
    localparam logic [18:0] M_ISP     = 19'd1 << 15;
    localparam logic [18:0] M_DSP     = 19'd1 << 16;
    localparam logic [18:0] M_RSP     = 19'd1 << 17;
    localparam logic [18:0] M_HALTED  = 19'd1 << 18;

    localparam logic [22:0] V_INIT  = {4'h0, M_CLR_PC | M_PSP};
    localparam logic [22:0] V_FETCH = {4'h0, M_WIR | M_INC_PC};
    localparam logic [22:0] V_HALT  = {4'h0, M_HALTED};

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [4:0] OPCODE = 5'd0;
    logic [2:0] STATUS_SEL = 3'd0;
    logic [7:0] STATUS = 8'd0;
    logic [3:0] ALU_OPERATION;
    logic INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT, READ_PROGCOUNT;
    logic WRITE_INSTREG, WRITE_REGS, USE_IMMEDIATE, USE_DISPLACEMENT;
    logic WRITE_MEM, READ_MEM, WRITE_MEMADDR;
    logic WRITE_STATREG, CLR_STATBIT, SET_STATBIT;
    logic PRESET_STACKPTR, INC_STACKPTR, DEC_STACKPTR, READ_STACKPTR;
    logic HALTED;

    logic [22:0] obs;
    logic [22:0] exp_q[$];
    int checks = 0;
    int fails = 0;

    yasac_control_unit #(
        .ALU_PASS_A(PA),
        .ALU_PASS_B(PB)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .OPCODE(OPCODE),
        .STATUS_SEL(STATUS_SEL),
        .STATUS(STATUS),
        .ALU_OPERATION(ALU_OPERATION),
        .INC_PROGCOUNT(INC_PROGCOUNT),
        .CLR_PROGCOUNT(CLR_PROGCOUNT),
        .WRITE_PROGCOUNT(WRITE_PROGCOUNT),
        .READ_PROGCOUNT(READ_PROGCOUNT),
        .WRITE_INSTREG(WRITE_INSTREG),
        .WRITE_REGS(WRITE_REGS),
        .USE_IMMEDIATE(USE_IMMEDIATE),
        .USE_DISPLACEMENT(USE_DISPLACEMENT),
        .WRITE_MEM(WRITE_MEM),
        .READ_MEM(READ_MEM),
        .WRITE_MEMADDR(WRITE_MEMADDR),
        .WRITE_STATREG(WRITE_STATREG),
        .CLR_STATBIT(CLR_STATBIT),
        .SET_STATBIT(SET_STATBIT),
        .PRESET_STACKPTR(PRESET_STACKPTR),
        .INC_STACKPTR(INC_STACKPTR),
        .DEC_STACKPTR(DEC_STACKPTR),
        .READ_STACKPTR(READ_STACKPTR),
        .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    assign obs = {ALU_OPERATION, HALTED, READ_STACKPTR, DEC_STACKPTR, INC_STACKPTR,
                  PRESET_STACKPTR, SET_STATBIT, CLR_STATBIT, WRITE_STATREG, WRITE_MEMADDR,
                  READ_MEM, WRITE_MEM, USE_DISPLACEMENT, USE_IMMEDIATE, WRITE_REGS,
                  WRITE_INSTREG, READ_PROGCOUNT, WRITE_PROGCOUNT, CLR_PROGCOUNT, INC_PROGCOUNT};

    task automatic check(input string tag, input logic [22:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s op=%b observed=%h expected=%h", tag, OPCODE, obs, expv);
        end
    endtask

    // Structural invariants, checked away from the active edge on every cycle.
    always @(negedge CLK) begin
        checks++;
        assert ($countones({READ_MEM, READ_STACKPTR, READ_PROGCOUNT}) <= 1)
        else begin
            fails++;
            $error("FAIL bus_sources observed=%b expected=at_most_one",
                   {READ_MEM, READ_STACKPTR, READ_PROGCOUNT});
        end
        checks++;
        assert ($countones({WRITE_STATREG, CLR_STATBIT, SET_STATBIT}) <= 1)
        else begin
            fails++;
            $error("FAIL stat_excl observed=%b expected=at_most_one",
                   {WRITE_STATREG, CLR_STATBIT, SET_STATBIT});
        end
        checks++;
        assert (!(INC_PROGCOUNT && WRITE_PROGCOUNT))
        else begin
            fails++;
            $error("FAIL pc_excl observed=11 expected=not_both");
        end
    end

    task automatic push(input logic [3:0] alu, input logic [18:0] m);
        exp_q.push_back({alu, m});
    endtask

    // Instruction table: the strobe set of each execute step, in order.
    task automatic build(input logic [4:0] op, input logic [2:0] sel, input logic [7:0] st);
        logic bit_v;
        bit_v = st[sel];
        exp_q.delete();
        if (op[4] == 1'b0) begin
            push(op[3:0], M_WREGS | M_WSTAT);
        end else begin
            case (op)
                5'b10000: push(PB, M_IMM | M_WREGS);
                5'b10001: begin push(PB, M_IMM | M_WMA); push(4'h0, M_RMEM | M_WREGS); end
                5'b10010: begin push(PB, M_IMM | M_WMA); push(PA, M_WMEM); end
                5'b10011: push(PB, M_IMM | M_WPC);
                5'b10100: if (bit_v) push(PB, M_IMM | M_WPC); else push(4'h0, 19'd0);
                5'b10101: if (!bit_v) push(PB, M_IMM | M_WPC); else push(4'h0, 19'd0);
                5'b10110: push(4'h0, M_CLRB);
                5'b10111: push(4'h0, M_SETB);
                5'b11000: begin push(4'h0, M_RSP | M_WMA | M_DSP); push(PA, M_WMEM); end
                5'b11001: begin
                    push(4'h0, M_ISP); push(4'h0, M_RSP | M_WMA); push(4'h0, M_RMEM | M_WREGS);
                end
                5'b11010: begin
                    push(4'h0, M_RSP | M_WMA | M_DSP); push(4'h0, M_RPC | M_WMEM);
                    push(PB, M_IMM | M_WPC);
                end
                5'b11011: begin
                    push(4'h0, M_ISP); push(4'h0, M_RSP | M_WMA); push(4'h0, M_RMEM | M_WPC);
                end
                default: push(4'h0, 19'd0);
            endcase
        end
    endtask

    // Entered 1 time unit after the edge that lands in FETCH; leaves at the next FETCH.
    task automatic run_instr(input logic [4:0] op, input logic [2:0] sel, input logic [7:0] st);
        OPCODE = op;
        STATUS_SEL = sel;
        STATUS = st;
        build(op, sel, st);
        #1 check("fetch", V_FETCH);
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #2 check("exec", exp_q.pop_front());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 check("reset_init", V_INIT);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // ST aborted by reset in E2.
        OPCODE = 5'b10010;
        #1 check("st_fetch", V_FETCH);
        @(posedge CLK);
        #2 check("st_e1", {PB, M_IMM | M_WMA});
        @(posedge CLK);
        #2 check("st_e2", {PA, M_WMEM});
        RESET_N = 1'b0;
        #1 check("abort_init", V_INIT);
        @(posedge CLK);
        #2 check("held_init", V_INIT);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        run_instr(5'b00011, 3'd0, 8'h00);
        run_instr(5'b10100, 3'd1, 8'h02);
        run_instr(5'b10100, 3'd1, 8'h00);
        run_instr(5'b10101, 3'd1, 8'h00);
        run_instr(5'b11010, 3'd0, 8'h00);
        run_instr(5'b11011, 3'd0, 8'h00);
        run_instr(5'b11000, 3'd0, 8'h00);
        run_instr(5'b11001, 3'd0, 8'h00);
        run_instr(5'b10001, 3'd0, 8'h00);
        run_instr(5'b10010, 3'd0, 8'h00);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 30));
            run_instr(op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        OPCODE = 5'b11111;
        #1 check("halt_fetch", V_FETCH);
        @(posedge CLK);
        #2 check("halt_e1", {4'h0, 19'd0});
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #2 check("halted", V_HALT);
        end
        RESET_N = 1'b0;
        #1 check("halt_reset", V_INIT);
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK);
        run_instr(5'b10000, 3'd0, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
